// File: rtl/xbus_arbiter_if.sv
// xbus arbiter signal bundle: two master request ports plus the shared xbus.
// The arbiter takes the slave view of the masters and drives the bus side.
interface xbus_arbiter_if;
  logic        m0_req;
  logic        m0_we;
  logic [31:0] m0_addr;
  logic [31:0] m0_wdata;
  logic [3:0]  m0_wstrb;
  logic        m0_ack;
  logic        m0_err;
  logic [31:0] m0_rdata;

  logic        m1_req;
  logic        m1_we;
  logic [31:0] m1_addr;
  logic [31:0] m1_wdata;
  logic [3:0]  m1_wstrb;
  logic        m1_ack;
  logic        m1_err;
  logic [31:0] m1_rdata;

  logic        xbus_as;
  logic        xbus_we;
  logic [31:0] xbus_addr;
  logic [31:0] xbus_wdata;
  logic [3:0]  xbus_wstrb;
  logic [31:0] xbus_rdata;
  logic        xbus_ready;
  logic        xbus_owner;

  // Requesters and the downstream slave: everything the arbiter samples.
  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata, m0_wstrb,
    input  m0_ack, m0_err, m0_rdata,
    output m1_req, m1_we, m1_addr, m1_wdata, m1_wstrb,
    input  m1_ack, m1_err, m1_rdata,
    input  xbus_as, xbus_we, xbus_addr, xbus_wdata, xbus_wstrb, xbus_owner,
    output xbus_rdata, xbus_ready
  );

  // Arbiter view.
  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata, m0_wstrb,
    output m0_ack, m0_err, m0_rdata,
    input  m1_req, m1_we, m1_addr, m1_wdata, m1_wstrb,
    output m1_ack, m1_err, m1_rdata,
    output xbus_as, xbus_we, xbus_addr, xbus_wdata, xbus_wstrb, xbus_owner,
    input  xbus_rdata, xbus_ready
  );
endinterface

// File: rtl/xbus_arbiter.sv
// Two-master round-robin arbiter that runs one registered xbus cycle at a time,
// with a watchdog that ends unanswered cycles as error completions.
//
// state | meaning
// IDLE  | bus free, sample requests and grant one master
// BUSY  | xbus_as high, waiting for xbus_ready or the watchdog
// DONE  | owner's ack pulses with err/rdata valid; requests ignored
module xbus_arbiter #(
  parameter int TIMEOUT = 255,
  parameter int TW      = 8
) (
  input  logic          clk,
  input  logic          rst,
  xbus_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [TW-1:0] CNT_LIMIT = TW'(TIMEOUT - 1);

  state_t        state, state_nxt;

  logic          as_q, as_nxt;
  logic          we_q, we_nxt;
  logic [31:0]   addr_q, addr_nxt;
  logic [31:0]   wdata_q, wdata_nxt;
  logic [3:0]    wstrb_q, wstrb_nxt;
  logic          owner_q, owner_nxt;
  logic          last_q, last_nxt;
  logic [TW-1:0] cnt_q, cnt_nxt;
  logic [1:0]    ack_q, ack_nxt;
  logic [1:0]    err_q, err_nxt;
  logic [31:0]   rdata0_q, rdata0_nxt;
  logic [31:0]   rdata1_q, rdata1_nxt;

  logic          any_req;
  logic          grant_sel;
  logic          complete;

  assign any_req   = bus.m0_req | bus.m1_req;
  // On a tie the master that did not win last time goes next.
  assign grant_sel = (bus.m0_req & bus.m1_req) ? ~last_q : bus.m1_req;
  assign complete  = bus.xbus_ready | (cnt_q == CNT_LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      as_q     <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      cnt_q    <= '0;
      ack_q    <= '0;
      err_q    <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state    <= state_nxt;
      as_q     <= as_nxt;
      we_q     <= we_nxt;
      addr_q   <= addr_nxt;
      wdata_q  <= wdata_nxt;
      wstrb_q  <= wstrb_nxt;
      owner_q  <= owner_nxt;
      last_q   <= last_nxt;
      cnt_q    <= cnt_nxt;
      ack_q    <= ack_nxt;
      err_q    <= err_nxt;
      rdata0_q <= rdata0_nxt;
      rdata1_q <= rdata1_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    as_nxt     = as_q;
    we_nxt     = we_q;
    addr_nxt   = addr_q;
    wdata_nxt  = wdata_q;
    wstrb_nxt  = wstrb_q;
    owner_nxt  = owner_q;
    last_nxt   = last_q;
    cnt_nxt    = cnt_q;
    ack_nxt    = 2'b00;
    err_nxt    = err_q;
    rdata0_nxt = rdata0_q;
    rdata1_nxt = rdata1_q;

    case (state)
      IDLE: begin
        if (any_req) begin
          as_nxt    = 1'b1;
          we_nxt    = grant_sel ? bus.m1_we    : bus.m0_we;
          addr_nxt  = grant_sel ? bus.m1_addr  : bus.m0_addr;
          wdata_nxt = grant_sel ? bus.m1_wdata : bus.m0_wdata;
          wstrb_nxt = grant_sel ? bus.m1_wstrb : bus.m0_wstrb;
          owner_nxt = grant_sel;
          last_nxt  = grant_sel;
          cnt_nxt   = '0;
          state_nxt = BUSY;
        end
      end

      BUSY: begin
        // Ready takes priority over the watchdog when both hit together.
        if (complete) begin
          as_nxt           = 1'b0;
          ack_nxt[owner_q] = 1'b1;
          err_nxt[owner_q] = ~bus.xbus_ready;
          if (owner_q) begin
            rdata1_nxt = bus.xbus_ready ? bus.xbus_rdata : '0;
          end else begin
            rdata0_nxt = bus.xbus_ready ? bus.xbus_rdata : '0;
          end
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt_q + TW'(1);
        end
      end

      DONE: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
        as_nxt    = 1'b0;
      end
    endcase
  end

  assign bus.xbus_as    = as_q;
  assign bus.xbus_we    = we_q;
  assign bus.xbus_addr  = addr_q;
  assign bus.xbus_wdata = wdata_q;
  assign bus.xbus_wstrb = wstrb_q;
  assign bus.xbus_owner = owner_q;

  assign bus.m0_ack     = ack_q[0];
  assign bus.m0_err     = err_q[0];
  assign bus.m0_rdata   = rdata0_q;
  assign bus.m1_ack     = ack_q[1];
  assign bus.m1_err     = err_q[1];
  assign bus.m1_rdata   = rdata1_q;

endmodule

// File: tb/tb_xbus_arbiter.sv
// Directed bench for xbus_arbiter, built with a short watchdog (TIMEOUT=4)
// so both the error completion and the ready-at-limit case are reachable.
module tb_xbus_arbiter;
  logic clk;
  logic rst;
  int   tests;
  int   fails;
  int   cyc;
  logic [31:0] exp_m0_rdata;
  logic [31:0] exp_m1_rdata;

  xbus_arbiter_if bus ();

  xbus_arbiter #(.TIMEOUT(4), .TW(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic do_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.m0_req = 1'b0; bus.m0_we = 1'b0; bus.m0_addr = '0; bus.m0_wdata = '0; bus.m0_wstrb = '0;
    bus.m1_req = 1'b0; bus.m1_we = 1'b0; bus.m1_addr = '0; bus.m1_wdata = '0; bus.m1_wstrb = '0;
    bus.xbus_ready = 1'b0;
    bus.xbus_rdata = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    do_cycle();
    do_cycle();
    tests++;
    if ({bus.xbus_as, bus.xbus_we, bus.xbus_owner, bus.xbus_wstrb} !== 7'd0) begin
      fails++;
      $display("FAIL reset_ctrl: got %b expected 0", {bus.xbus_as, bus.xbus_we, bus.xbus_owner, bus.xbus_wstrb});
    end
    tests++;
    if ({bus.xbus_addr, bus.xbus_wdata} !== 64'd0) begin
      fails++;
      $display("FAIL reset_bus: got %h expected 0", {bus.xbus_addr, bus.xbus_wdata});
    end
    tests++;
    if ({bus.m0_ack, bus.m0_err, bus.m0_rdata, bus.m1_ack, bus.m1_err, bus.m1_rdata} !== 68'd0) begin
      fails++;
      $display("FAIL reset_masters: got %h expected 0",
               {bus.m0_ack, bus.m0_err, bus.m0_rdata, bus.m1_ack, bus.m1_err, bus.m1_rdata});
    end
    rst = 1'b0;
    do_cycle();
  endtask

  task automatic test_single_read();
    bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 32'h0000_1000;
    do_cycle();
    tests++;
    if ({bus.xbus_as, bus.xbus_we, bus.xbus_owner} !== 3'b100 || bus.xbus_addr !== 32'h0000_1000) begin
      fails++;
      $display("FAIL read_grant: got as/we/own=%b addr=%h expected 100 00001000",
               {bus.xbus_as, bus.xbus_we, bus.xbus_owner}, bus.xbus_addr);
    end
    do_cycle();
    tests++;
    if (bus.xbus_as !== 1'b1 || bus.m0_ack !== 1'b0) begin
      fails++;
      $display("FAIL read_busy2: got as=%b ack=%b expected as=1 ack=0", bus.xbus_as, bus.m0_ack);
    end
    bus.xbus_ready = 1'b1; bus.xbus_rdata = 32'hDEAD_BEEF;
    do_cycle();
    tests++;
    if ({bus.xbus_as, bus.m0_ack, bus.m0_err, bus.m1_ack} !== 4'b0100 || bus.m0_rdata !== 32'hDEAD_BEEF) begin
      fails++;
      $display("FAIL read_ack: got as/ack/err/ack1=%b rdata=%h expected 0100 deadbeef",
               {bus.xbus_as, bus.m0_ack, bus.m0_err, bus.m1_ack}, bus.m0_rdata);
    end
    bus.xbus_ready = 1'b0; bus.m0_req = 1'b0;
    do_cycle();
    tests++;
    if ({bus.m0_ack, bus.m1_ack, bus.xbus_as} !== 3'b000) begin
      fails++;
      $display("FAIL read_ack_pulse: got ack0/ack1/as=%b expected 000", {bus.m0_ack, bus.m1_ack, bus.xbus_as});
    end
  endtask

  task automatic test_round_robin();
    int prev;
    prev = 0;
    rst = 1'b1;
    do_cycle();
    rst = 1'b0;
    bus.m0_req = 1'b1; bus.m0_addr = 32'h0000_0100;
    bus.m1_req = 1'b1; bus.m1_addr = 32'h0000_0200;
    bus.xbus_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      do_cycle();
      tests++;
      if (bus.xbus_owner !== 1'(i % 2) || bus.xbus_as !== 1'b1
          || bus.xbus_addr !== ((i % 2) ? 32'h0000_0200 : 32'h0000_0100)) begin
        fails++;
        $display("FAIL rr_owner[%0d]: got owner=%b as=%b addr=%h expected owner=%0d as=1",
                 i, bus.xbus_owner, bus.xbus_as, bus.xbus_addr, i % 2);
      end
      bus.xbus_rdata = 32'hA000_0000 + 32'(i);
      do_cycle();
      tests++;
      if ({bus.m1_ack, bus.m0_ack} !== ((i % 2) ? 2'b10 : 2'b01)
          || ((i % 2) ? bus.m1_rdata : bus.m0_rdata) !== 32'hA000_0000 + 32'(i)) begin
        fails++;
        $display("FAIL rr_ack[%0d]: got acks=%b rdata0=%h rdata1=%h", i, {bus.m1_ack, bus.m0_ack},
                 bus.m0_rdata, bus.m1_rdata);
      end
      if (i > 0) begin
        tests++;
        if (cyc - prev !== 3) begin
          fails++;
          $display("FAIL rr_spacing[%0d]: got %0d cycles expected 3", i, cyc - prev);
        end
      end
      prev = cyc;
      do_cycle();
    end
    exp_m0_rdata = 32'hA000_0002;
    bus.m0_req = 1'b0; bus.m1_req = 1'b0; bus.xbus_ready = 1'b0;
    do_cycle();
  endtask

  task automatic test_write();
    bus.m1_req = 1'b1; bus.m1_we = 1'b1; bus.m1_addr = 32'h8000_0004;
    bus.m1_wdata = 32'h1234_5678; bus.m1_wstrb = 4'h3;
    do_cycle();
    tests++;
    if ({bus.xbus_as, bus.xbus_we, bus.xbus_owner, bus.xbus_wstrb} !== 7'b111_0011
        || bus.xbus_addr !== 32'h8000_0004 || bus.xbus_wdata !== 32'h1234_5678) begin
      fails++;
      $display("FAIL write_bus: got ctl=%b addr=%h wdata=%h expected 1110011 80000004 12345678",
               {bus.xbus_as, bus.xbus_we, bus.xbus_owner, bus.xbus_wstrb}, bus.xbus_addr, bus.xbus_wdata);
    end
    bus.m1_addr = 32'hFFFF_FFFF; bus.m1_wdata = 32'h0; bus.m1_wstrb = 4'hF; bus.m1_we = 1'b0;
    do_cycle();
    tests++;
    if ({bus.xbus_as, bus.xbus_we, bus.xbus_wstrb} !== 6'b11_0011
        || bus.xbus_addr !== 32'h8000_0004 || bus.xbus_wdata !== 32'h1234_5678) begin
      fails++;
      $display("FAIL write_hold: got ctl=%b addr=%h wdata=%h expected 110011 80000004 12345678",
               {bus.xbus_as, bus.xbus_we, bus.xbus_wstrb}, bus.xbus_addr, bus.xbus_wdata);
    end
    bus.xbus_ready = 1'b1; bus.xbus_rdata = 32'h5555_AAAA;
    do_cycle();
    exp_m1_rdata = 32'h5555_AAAA;
    tests++;
    if ({bus.m1_ack, bus.m1_err, bus.m0_ack} !== 3'b100 || bus.m1_rdata !== exp_m1_rdata
        || bus.m0_rdata !== exp_m0_rdata) begin
      fails++;
      $display("FAIL write_ack: got ack1/err1/ack0=%b rdata1=%h rdata0=%h expected 100 %h %h",
               {bus.m1_ack, bus.m1_err, bus.m0_ack}, bus.m1_rdata, bus.m0_rdata, exp_m1_rdata, exp_m0_rdata);
    end
    bus.m1_req = 1'b0; bus.xbus_ready = 1'b0;
    do_cycle();
    do_cycle();
    tests++;
    if ({bus.xbus_owner, bus.xbus_as, bus.m1_ack} !== 3'b100) begin
      fails++;
      $display("FAIL write_owner_kept: got owner/as/ack=%b expected 100", {bus.xbus_owner, bus.xbus_as, bus.m1_ack});
    end
  endtask

  task automatic test_timeout();
    int as_cnt;
    as_cnt = 0;
    bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 32'h4000_0000;
    bus.xbus_rdata = 32'h7777_7777;
    do_cycle();
    for (int c = 0; c < 10 && bus.xbus_as === 1'b1; c++) begin
      as_cnt++;
      do_cycle();
    end
    tests++;
    if (as_cnt !== 4) begin
      fails++;
      $display("FAIL timeout_as_len: got %0d cycles expected 4", as_cnt);
    end
    tests++;
    if ({bus.m0_ack, bus.m0_err, bus.m1_ack} !== 3'b110 || bus.m0_rdata !== 32'h0) begin
      fails++;
      $display("FAIL timeout_err: got ack/err/ack1=%b rdata=%h expected 110 00000000",
               {bus.m0_ack, bus.m0_err, bus.m1_ack}, bus.m0_rdata);
    end
    bus.m0_req = 1'b0;
    do_cycle();
    tests++;
    if (bus.m0_ack !== 1'b0 || bus.m1_rdata !== exp_m1_rdata || bus.m1_err !== 1'b0) begin
      fails++;
      $display("FAIL timeout_after: got ack0=%b rdata1=%h err1=%b expected 0 %h 0",
               bus.m0_ack, bus.m1_rdata, bus.m1_err, exp_m1_rdata);
    end
  endtask

  task automatic test_ready_at_limit();
    bus.m0_req = 1'b1; bus.m0_addr = 32'h4000_0010;
    do_cycle();
    do_cycle();
    do_cycle();
    do_cycle();
    tests++;
    if (bus.xbus_as !== 1'b1 || bus.m0_ack !== 1'b0) begin
      fails++;
      $display("FAIL limit_busy4: got as=%b ack=%b expected 1 0", bus.xbus_as, bus.m0_ack);
    end
    bus.xbus_ready = 1'b1; bus.xbus_rdata = 32'hCAFE_F00D;
    do_cycle();
    tests++;
    if ({bus.m0_ack, bus.m0_err, bus.xbus_as} !== 3'b100 || bus.m0_rdata !== 32'hCAFE_F00D) begin
      fails++;
      $display("FAIL limit_ready_wins: got ack/err/as=%b rdata=%h expected 100 cafef00d",
               {bus.m0_ack, bus.m0_err, bus.xbus_as}, bus.m0_rdata);
    end
    bus.m0_req = 1'b0; bus.xbus_ready = 1'b0;
    do_cycle();
  endtask

  task automatic test_reset_mid_busy();
    bus.m0_req = 1'b1; bus.m0_addr = 32'h0000_2000;
    do_cycle();
    tests++;
    if (bus.xbus_as !== 1'b1 || bus.xbus_owner !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_grant: got as=%b owner=%b expected 1 0", bus.xbus_as, bus.xbus_owner);
    end
    do_cycle();
    rst = 1'b1;
    #1;
    tests++;
    if ({bus.xbus_as, bus.m0_ack, bus.m1_ack} !== 3'b000) begin
      fails++;
      $display("FAIL rstmid_async: got as/ack0/ack1=%b expected 000", {bus.xbus_as, bus.m0_ack, bus.m1_ack});
    end
    bus.xbus_ready = 1'b1;
    bus.m1_req = 1'b1; bus.m1_addr = 32'h0000_3000;
    do_cycle();
    do_cycle();
    tests++;
    if ({bus.xbus_as, bus.m0_ack, bus.m1_ack} !== 3'b000) begin
      fails++;
      $display("FAIL rstmid_no_ack: got as/ack0/ack1=%b expected 000", {bus.xbus_as, bus.m0_ack, bus.m1_ack});
    end
    bus.xbus_ready = 1'b0;
    rst = 1'b0;
    do_cycle();
    tests++;
    if ({bus.xbus_as, bus.xbus_owner, bus.m0_ack, bus.m1_ack} !== 4'b1000 || bus.xbus_addr !== 32'h0000_2000) begin
      fails++;
      $display("FAIL rstmid_m0_first: got as/own/ack0/ack1=%b addr=%h expected 1000 00002000",
               {bus.xbus_as, bus.xbus_owner, bus.m0_ack, bus.m1_ack}, bus.xbus_addr);
    end
    bus.m0_req = 1'b0; bus.m1_req = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    cyc = 0;
    exp_m0_rdata = '0;
    exp_m1_rdata = '0;
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_single_read();
    test_round_robin();
    test_write();
    test_timeout();
    test_ready_at_limit();
    test_reset_mid_busy();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "time limit");
  end
endmodule
